// File: rtl/pb_io_bank.sv
// rtl/pb_io_bank.sv - PicoBlaze I/O bank: write shadows with commit handshake, snapshot read-back, key flags, in_port mux
// Optional KEY_DEBOUNCE_EN inserts a per-key debounce filter ahead of key edge detection.
module pb_io_bank #(
  parameter int         N_REG    = 9,
  parameter int         W        = 8,
  parameter logic [7:0] WR_BASE  = 8'h10,
  parameter logic [7:0] RD_BASE  = 8'h20,
  parameter logic [7:0] KEY_ID   = 8'h30,
  parameter logic [7:0] CTRL_ID  = 8'h31,
  parameter int         N_KEY    = 7,
  parameter int         HOLD_CYC = 4,
  parameter int         SNAP_TO  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         in_port,
  input  logic [N_KEY-1:0]   keys,
  input  logic [N_REG*W-1:0] rd_src,
  input  logic               src_valid,
  output logic [N_REG*W-1:0] wr_data,
  output logic [N_REG-1:0]   habilita,
  output logic               commit,
  output logic               busy
);
  localparam int LW      = (W < 8) ? W : 8;
  localparam int CNT_MAX = (HOLD_CYC > SNAP_TO) ? HOLD_CYC : SNAP_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_SNAP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       shadow_q [N_REG];
  logic [W-1:0]       shadow_d [N_REG];
  logic [W-1:0]       rd_reg_q [N_REG];
  logic [W-1:0]       rd_reg_d [N_REG];
  logic [N_REG*W-1:0] wr_data_q, wr_data_d;
  logic [N_REG-1:0]   dirty_q, dirty_d;
  logic [N_REG-1:0]   rewrite_q, rewrite_d;
  logic [N_REG-1:0]   habilita_q, habilita_d;
  logic               commit_q, commit_d;
  logic               err_q, err_d;
  logic               snap_ok_q, snap_ok_d;
  logic [N_KEY-1:0]   key_s1_q, key_s1_d;
  logic [N_KEY-1:0]   key_s2_q, key_s2_d;
  logic [N_KEY-1:0]   key_prev_q, key_prev_d;
  logic [N_KEY-1:0]   flags_q, flags_d;
  logic [N_KEY-1:0]   key_lvl, key_edge;
  logic [7:0]         in_port_q, in_port_d;

  logic [7:0]         wr_off, rd_off;
  logic               wr_hit, rd_hit, ctrl_wr, key_rd;
  logic [N_REG-1:0]   wr_mask;

  assign in_port  = in_port_q;
  assign wr_data  = wr_data_q;
  assign habilita = habilita_q;
  assign commit   = commit_q;
  assign busy     = (state_q != S_IDLE);

`ifdef KEY_DEBOUNCE_EN
  localparam int DB_CYC = 50000;
  logic [15:0]      db_cnt_q [N_KEY];
  logic [15:0]      db_cnt_d [N_KEY];
  logic [N_KEY-1:0] db_lvl_q, db_lvl_d;

  // Counter restarts whenever the synchronised input agrees with the filtered level.
  always_comb begin
    db_lvl_d = db_lvl_q;
    for (int k = 0; k < N_KEY; k++) begin
      db_cnt_d[k] = '0;
      if (key_s2_q[k] != db_lvl_q[k]) begin
        if (db_cnt_q[k] == 16'(DB_CYC - 1)) begin
          db_lvl_d[k] = key_s2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q <= '{default: '0};
      db_lvl_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign key_lvl = db_lvl_q;
`else
  assign key_lvl = key_s2_q;
`endif

  always_comb begin
    wr_off   = port_id - WR_BASE;
    rd_off   = port_id - RD_BASE;
    wr_hit   = write_strobe && (wr_off < 8'(N_REG));
    rd_hit   = (rd_off < 8'(N_REG));
    ctrl_wr  = write_strobe && (port_id == CTRL_ID);
    key_rd   = read_strobe && (port_id == KEY_ID);
    key_edge = key_lvl & ~key_prev_q;
    wr_mask  = '0;
    for (int i = 0; i < N_REG; i++) begin
      wr_mask[i] = wr_hit && (wr_off == 8'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    rd_reg_d   = rd_reg_q;
    wr_data_d  = wr_data_q;
    dirty_d    = dirty_q | wr_mask;
    rewrite_d  = rewrite_q;
    habilita_d = habilita_q;
    commit_d   = commit_q;
    err_d      = err_q;
    snap_ok_d  = snap_ok_q;

    for (int i = 0; i < N_REG; i++) begin
      if (wr_mask[i]) shadow_d[i][LW-1:0] = out_port[LW-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && (out_port[0] || out_port[1])) begin
          err_d     = 1'b0;
          snap_ok_d = 1'b0;
          cnt_d     = '0;
          if (out_port[0]) begin
            if (dirty_q == '0) begin
              err_d = 1'b1;
            end else begin
              state_d    = S_COMMIT;
              commit_d   = 1'b1;
              habilita_d = dirty_q;
              rewrite_d  = '0;
              for (int i = 0; i < N_REG; i++) begin
                if (dirty_q[i]) wr_data_d[i*W +: W] = shadow_q[i];
              end
            end
          end else begin
            state_d = S_SNAP;
          end
        end
      end
      S_COMMIT: begin
        // Fields rewritten while the commit is in flight must stay dirty for the next commit.
        rewrite_d = rewrite_q | wr_mask;
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d    = S_IDLE;
          commit_d   = 1'b0;
          habilita_d = '0;
          dirty_d    = (dirty_q & ~habilita_q) | rewrite_q | wr_mask;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SNAP: begin
        if (src_valid) begin
          for (int i = 0; i < N_REG; i++) begin
            rd_reg_d[i] = rd_src[i*W +: W];
          end
          snap_ok_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == CW'(SNAP_TO - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    key_s1_d   = keys;
    key_s2_d   = key_s1_q;
    key_prev_d = key_lvl;
    flags_d    = flags_q;
    // A key read returns every current flag, so all of them clear; a same-cycle edge still lands.
    if (key_rd || (ctrl_wr && out_port[2])) flags_d = '0;
    flags_d = flags_d | key_edge;

    in_port_d = 8'h00;
    if (rd_hit) begin
      for (int i = 0; i < N_REG; i++) begin
        if (rd_off == 8'(i)) in_port_d[LW-1:0] = rd_reg_q[i][LW-1:0];
      end
    end else if (port_id == KEY_ID) begin
      in_port_d[N_KEY-1:0] = flags_q;
    end else if (port_id == CTRL_ID) begin
      in_port_d = {4'b0, err_q, snap_ok_q, |dirty_q, busy};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '{default: '0};
      rd_reg_q   <= '{default: '0};
      wr_data_q  <= '0;
      dirty_q    <= '0;
      rewrite_q  <= '0;
      habilita_q <= '0;
      commit_q   <= 1'b0;
      err_q      <= 1'b0;
      snap_ok_q  <= 1'b0;
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      key_prev_q <= '0;
      flags_q    <= '0;
      in_port_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      rd_reg_q   <= rd_reg_d;
      wr_data_q  <= wr_data_d;
      dirty_q    <= dirty_d;
      rewrite_q  <= rewrite_d;
      habilita_q <= habilita_d;
      commit_q   <= commit_d;
      err_q      <= err_d;
      snap_ok_q  <= snap_ok_d;
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_prev_q <= key_prev_d;
      flags_q    <= flags_d;
      in_port_q  <= in_port_d;
    end
  end

endmodule

// File: tb/tb_pb_io_bank.sv
// tb/tb_pb_io_bank.sv - directed table-driven bench for pb_io_bank
module tb_pb_io_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id, out_port;
  logic        write_strobe, read_strobe;
  logic [7:0]  in_port;
  logic [6:0]  keys;
  logic [71:0] rd_src;
  logic        src_valid;
  logic [71:0] wr_data;
  logic [8:0]  habilita;
  logic        commit, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pb_io_bank dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
    .keys(keys), .rd_src(rd_src), .src_valid(src_valid), .wr_data(wr_data),
    .habilita(habilita), .commit(commit), .busy(busy)
  );

  typedef struct {
    logic [7:0] pid;
    logic [7:0] dout;
    logic       ws;
    logic [7:0] exp_in;
    logic       exp_commit;
    logic       exp_busy;
    logic [8:0] exp_hab;
  } vec_t;

  vec_t tbl [26];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [7:0] pid, input logic [7:0] d, input logic ws, input logic rs);
    port_id      = pid;
    out_port     = d;
    write_strobe = ws;
    read_strobe  = rs;
    cyc();
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
  endtask

  logic [71:0] exp_wr;

  initial begin
    //          pid    dout   ws    in     cm    bz    hab
    tbl[0]  = '{8'h10, 8'h24, 1'b1, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[1]  = '{8'h12, 8'h15, 1'b1, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[2]  = '{8'h31, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0, 9'h000};
    tbl[3]  = '{8'h31, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1, 9'h005};
    tbl[4]  = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h005};
    tbl[5]  = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h005};
    tbl[6]  = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h005};
    tbl[7]  = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 9'h000};
    tbl[8]  = '{8'h31, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[9]  = '{8'h19, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[10] = '{8'h31, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[11] = '{8'h18, 8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[12] = '{8'h31, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1, 9'h100};
    tbl[13] = '{8'h11, 8'h33, 1'b1, 8'h00, 1'b1, 1'b1, 9'h100};
    tbl[14] = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h100};
    tbl[15] = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h100};
    tbl[16] = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 9'h000};
    tbl[17] = '{8'h31, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0, 9'h000};
    tbl[18] = '{8'h31, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1, 9'h002};
    tbl[19] = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h002};
    tbl[20] = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h002};
    tbl[21] = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 9'h002};
    tbl[22] = '{8'h31, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 9'h000};
    tbl[23] = '{8'h31, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[24] = '{8'h31, 8'h03, 1'b1, 8'h00, 1'b0, 1'b0, 9'h000};
    tbl[25] = '{8'h31, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0, 9'h000};

    reset = 1'b0; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0; keys = '0; src_valid = 1'b0;
    rd_src = '0;
    for (int i = 0; i < 9; i++) rd_src[i*8 +: 8] = 8'hA0 + 8'(i);
    rd_src[31:24] = 8'h59;

    // Reset held with keys toggling
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? 7'h55 : 7'h2A;
      port_id = 8'h30;
      cyc();
    end
    check("rst_in_port", in_port, 8'h00);
    check("rst_commit", commit, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_habilita", habilita, 9'h000);
    check("rst_wr_data", wr_data, 72'h0);
    keys = '0;
    reset = 1'b1;
    bus(8'h31, 8'h00, 1'b0, 1'b0);
    check("rst_status", in_port, 8'h00);

    for (int v = 0; v < 26; v++) begin
      bus(tbl[v].pid, tbl[v].dout, tbl[v].ws, 1'b0);
      check($sformatf("vec%0d_in_port", v), in_port, tbl[v].exp_in);
      check($sformatf("vec%0d_commit", v), commit, tbl[v].exp_commit);
      check($sformatf("vec%0d_busy", v), busy, tbl[v].exp_busy);
      check($sformatf("vec%0d_habilita", v), habilita, tbl[v].exp_hab);
    end
    exp_wr = '0;
    exp_wr[7:0]   = 8'h24;
    exp_wr[15:8]  = 8'h33;
    exp_wr[23:16] = 8'h15;
    exp_wr[71:64] = 8'h77;
    check("wr_data_fields", wr_data, exp_wr);

    // Snapshot with src_valid after 10 cycles; a commit request while busy is ignored
    bus(8'h31, 8'h02, 1'b1, 1'b0);
    check("snap_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) bus(8'h31, 8'h00, 1'b0, 1'b0);
    bus(8'h31, 8'h01, 1'b1, 1'b0);
    check("busy_ignore", busy, 1'b1);
    for (int i = 0; i < 4; i++) bus(8'h31, 8'h00, 1'b0, 1'b0);
    src_valid = 1'b1;
    bus(8'h31, 8'h00, 1'b0, 1'b0);
    src_valid = 1'b0;
    check("snap_done", busy, 1'b0);
    bus(8'h23, 8'h00, 1'b0, 1'b0);
    check("snap_field3", in_port, 8'h59);
    bus(8'h28, 8'h00, 1'b0, 1'b0);
    check("snap_field8", in_port, 8'hA8);
    bus(8'h29, 8'h00, 1'b0, 1'b0);
    check("rd_out_of_range", in_port, 8'h00);
    bus(8'h31, 8'h00, 1'b0, 1'b0);
    check("snap_status", in_port, 8'h04);

    // Snapshot timeout
    bus(8'h31, 8'h02, 1'b1, 1'b0);
    for (int i = 1; i <= 254; i++) bus(8'h31, 8'h00, 1'b0, 1'b0);
    check("snap_to_wait", busy, 1'b1);
    bus(8'h31, 8'h00, 1'b0, 1'b0);
    check("snap_to_exit", busy, 1'b0);
    bus(8'h31, 8'h00, 1'b0, 1'b0);
    check("snap_to_err", in_port, 8'h08);
    bus(8'h23, 8'h00, 1'b0, 1'b0);
    check("snap_to_keep", in_port, 8'h59);

    // Key flags
    keys[1] = 1'b1; for (int i = 0; i < 3; i++) cyc();
    keys[1] = 1'b0; for (int i = 0; i < 3; i++) cyc();
    for (int p = 0; p < 2; p++) begin
      keys[4] = 1'b1; for (int i = 0; i < 3; i++) cyc();
      keys[4] = 1'b0; for (int i = 0; i < 3; i++) cyc();
    end
    bus(8'h30, 8'h00, 1'b0, 1'b1);
    check("key_read1", in_port, 8'h12);
    bus(8'h30, 8'h00, 1'b0, 1'b1);
    check("key_read2", in_port, 8'h00);
    keys[0] = 1'b1;
    port_id = 8'h30;
    cyc();
    cyc();
    bus(8'h30, 8'h00, 1'b0, 1'b1);
    check("key_coincident_ret", in_port, 8'h00);
    bus(8'h30, 8'h00, 1'b0, 1'b0);
    check("key_survive", in_port, 8'h01);
    bus(8'h30, 8'h00, 1'b0, 1'b1);
    keys[0] = 1'b0;

    // Reset in the second commit cycle
    bus(8'h10, 8'h24, 1'b1, 1'b0);
    bus(8'h31, 8'h01, 1'b1, 1'b0);
    check("mid_commit_up", commit, 1'b1);
    bus(8'h31, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_commit", commit, 1'b0);
    check("mid_rst_habilita", habilita, 9'h000);
    check("mid_rst_wr_data", wr_data, 72'h0);
    check("mid_rst_busy", busy, 1'b0);
    reset = 1'b1;
    bus(8'h31, 8'h00, 1'b0, 1'b0);
    check("mid_rst_status", in_port, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pb_io_bank.md
Name: pb_io_bank

Overview:
Parametrised PicoBlaze (kcpsm6) I/O bank; successor to the fixed keyboard register, in_port mux and RTC register trio. Provides N_REG write-shadow registers with a dirty-mask commit handshake toward the RTC controller, and N_REG snapshot read-back registers loaded on a src_valid handshake. Also provides N_KEY edge-latched key flags and a registered in_port mux. Sits between the processor port bus and the RTC/display logic.

Parameters:
N_REG, 9, number of data fields (ano..st); 1..16
W, 8, field width in bits
WR_BASE, 8'h10, port_id of write-shadow field 0; fields at WR_BASE+i
RD_BASE, 8'h20, port_id of read-back field 0; fields at RD_BASE+i
KEY_ID, 8'h30, port_id of key-flag register
CTRL_ID, 8'h31, port_id of control (write) / status (read) register
N_KEY, 7, number of key inputs; at most 8
HOLD_CYC, 4, cycles that commit/habilita are held; at least 1
SNAP_TO, 255, snapshot timeout in cycles

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
port_id  in  8  processor port address
out_port  in  8  processor write data
write_strobe  in  1  processor write qualifier
read_strobe  in  1  processor read qualifier
in_port  out  8  registered read data to processor
keys  in  N_KEY  raw key levels (aumenta, disminuye, ...); asynchronous
rd_src  in  N_REG*W  RTC read-back fields; field i at [i*W +: W]
src_valid  in  1  RTC read data valid (Listo_es)
wr_data  out  N_REG*W  committed fields to RTC
habilita  out  N_REG  per-field write enable; valid while commit=1
commit  out  1  commit handshake (Listo_ht)
busy  out  1  FSM not IDLE

Behaviour:
- Reset (reset=0) clears immediately: all shadows, wr_data, read regs, key flags, dirty, habilita, commit, busy, in_port. FSM goes to IDLE. Reset mid-commit or mid-snapshot aborts it; no partial outputs remain.
- Write to a field: write_strobe=1 and port_id=WR_BASE+i with i<N_REG. Next edge: shadow[i]<=out_port[W-1:0] and dirty[i]<=1. Writes are accepted in every state.
- Out-of-range port_id on a write: ignored.
- Control write (port_id=CTRL_ID, write_strobe=1):
  - bit0: commit request.
  - bit1: snapshot request.
  - bit2: clear all key flags.
  - Requests are accepted only in IDLE and are dropped when busy=1.
  - If bit0 and bit1 are both set, commit takes priority and the snapshot is dropped.
- FSM states and transitions:
  - IDLE -> COMMIT on a commit request. If dirty=0, the FSM stays in IDLE and sets status bit err.
  - COMMIT, first edge: wr_data[i]<=shadow[i] for each dirty i; habilita<=dirty; commit<=1. Held for exactly HOLD_CYC cycles.
  - COMMIT exit: habilita<=0, commit<=0, dirty<=0, -> IDLE. The exit clear must not clear dirty bits set by writes during COMMIT.
  - IDLE -> SNAP on a snapshot request. SNAP waits for src_valid=1, then captures all rd_src into the read regs, sets snap_ok, -> IDLE.
  - SNAP timeout: after SNAP_TO cycles with no src_valid, sets err and -> IDLE.
  - Any new request clears snap_ok and err.
- Keys: 2-FF synchroniser, then rising-edge detect; each edge sets flag[k].
- Key flag clear: a read at KEY_ID (read_strobe=1) clears the flags that were returned. An edge arriving on the same cycle as the clear survives.
- Read mux, registered, 1-cycle latency; in_port updates every cycle from port_id:
  - RD_BASE+i: read reg i.
  - KEY_ID: flags, zero-extended.
  - CTRL_ID status: {4'b0, err, snap_ok, |dirty, busy}.
  - Any other port_id: 8'h00.
- W<8: read data zero-extended. W>8: only low 8 bits are writable and readable.

Optional Feature:
KEY_DEBOUNCE_EN: when defined, each synchronised key passes through a debounce counter with localparam DB_CYC=50000. The filtered level changes only after the input has been stable for DB_CYC consecutive cycles. Edge detection runs on the filtered level. When undefined: no debounce; edges are taken directly from the synchroniser output.

Test Plan:
- Reset: hold reset=0 with keys toggling -> all outputs 0, in_port=00; after release status read =00.
- Write port 0x10=0x24 and 0x12=0x15, then CTRL_ID=0x01 -> commit=1 and habilita=9'b000000101 for 4 cycles; wr_data field0=0x24, field2=0x15; dirty cleared; busy falls on the 5th cycle.
- CTRL_ID=0x02, src_valid raised after 10 cycles with rd_src field3=0x59 -> read 0x23 returns 0x59 one cycle after port_id; status=0x04. Repeat with src_valid never raised -> status=0x08 (err) after 255 cycles.
- Pulse keys[1] once (two edges on keys[4]) -> read KEY_ID=0x12; second read=0x00. Edge on keys[0] coincident with the read -> next read=0x01.
- Reset asserted during COMMIT cycle 2 -> commit and habilita drop immediately; wr_data=0.
- CTRL_ID=0x03 with dirty=0 -> err=1, no commit, no snapshot; CTRL_ID write while busy -> ignored.
